tug_input_conditioner: RTL and testbench

Converts the two raw, asynchronous, active-low player push-buttons of the two-player tug-of-war game into the clean single-cycle `L`/`R` press pulses consumed by the playfield light FSMs. Each button passes through a 2-flop synchronizer, then a per-channel debounce state machine that emits exactly one pulse per debounced press. A shared stage gates pulses with the game-enable signal and cancels simultaneous presses.

---
 rtl/tug_input_conditioner.sv | 130 +++++++++++++
 tb/tb_tug_input_conditioner.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/tug_input_conditioner.sv
// Two-player button front end: per-key synchronizer and debounce FSM, then a shared
// output stage that gates presses with enable and turns simultaneous presses into a tie.
module tug_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    input  logic enable,
    output logic L,
    output logic R,
    output logic tie
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        REL_PEND
    } state_t;

    logic [1:0] key_n;
    logic [1:0] acc;

    assign key_n = {key_r_n, key_l_n};

    // Channel 0 is the left key, channel 1 the right key.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic          sync1_q;
            logic          sync2_q;
            logic          s;
            state_t        state_q;
            logic [CW-1:0] cnt_q;
            logic          acc_q;

            assign s       = ~sync2_q;
            assign acc[gi] = acc_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                end else begin
                    sync1_q <= key_n[gi];
                    sync2_q <= sync1_q;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                    acc_q   <= 1'b0;
                end else begin
                    acc_q <= 1'b0;
                    case (state_q)
                        RELEASED: begin
                            if (s) begin
                                state_q <= PRESS_PEND;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                        PRESS_PEND: begin
                            if (!s) begin
                                state_q <= RELEASED;
                                cnt_q   <= '0;
                            end else if (cnt_q == CNT_MAX) begin
                                state_q <= PRESSED;
                                acc_q   <= 1'b1;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end
                        // A held key stays here; only a debounced release re-arms the channel.
                        PRESSED: begin
                            if (!s) begin
                                state_q <= REL_PEND;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                        REL_PEND: begin
                            if (s) begin
                                state_q <= PRESSED;
                                cnt_q   <= '0;
                            end else if (cnt_q == CNT_MAX) begin
                                state_q <= RELEASED;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end
                        default: begin
                            state_q <= RELEASED;
                            cnt_q   <= '0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    logic l_q;
    logic r_q;
    logic tie_q;

    // Acceptances while disabled are dropped, never deferred.
    always_ff @(posedge clk) begin
        if (reset) begin
            l_q   <= 1'b0;
            r_q   <= 1'b0;
            tie_q <= 1'b0;
        end else begin
            l_q   <= enable & acc[0] & ~acc[1];
            r_q   <= enable & acc[1] & ~acc[0];
            tie_q <= enable & acc[0] & acc[1];
        end
    end

    assign L   = l_q;
    assign R   = r_q;
    assign tie = tie_q;

endmodule

// File: tb/tb_tug_input_conditioner.sv
// Scoreboard bench for tug_input_conditioner: each driven press pushes the expected
// pulse (cycle and kind); the monitor pops and compares whenever an output fires.
module tb_tug_input_conditioner;

    localparam int D = 4;
    localparam logic [2:0] K_L   = 3'b100;
    localparam logic [2:0] K_R   = 3'b010;
    localparam logic [2:0] K_TIE = 3'b001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_l_n = 1'b1;
    logic key_r_n = 1'b1;
    logic enable = 1'b1;
    logic L, R, tie;

    tug_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk    (clk),
        .reset  (reset),
        .key_l_n(key_l_n),
        .key_r_n(key_r_n),
        .enable (enable),
        .L      (L),
        .R      (R),
        .tie    (tie)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    logic rst_applied = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input int got, input int expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_applied <= reset;
    end

    // Outputs change on posedge only, so the negedge sees settled values.
    always @(negedge clk) begin
        logic [2:0] obs;
        exp_t       e;
        obs = {L, R, tie};
        if (rst_applied) begin
            check("reset_out", int'(obs), 0);
        end else if (obs != 3'b000) begin
            if (sb_q.size() == 0) begin
                check("unexpected", int'(obs), 0);
            end else begin
                e = sb_q.pop_front();
                check("pulse_kind", int'(obs), int'(e.kind));
                check("pulse_cyc", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge right after the key edge is driven: the key is first
    // sampled at the next posedge, and the pulse appears D+3 edges after that.
    task automatic expect_pulse(input logic [2:0] kind);
        exp_t e;
        e.cyc  = cyc + 1 + D + 3;
        e.kind = kind;
        sb_q.push_back(e);
        $display("push %b expected at cycle %0d", kind, e.cyc);
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick(5);

        // Clean left press
        key_l_n = 1'b0; expect_pulse(K_L);
        tick(20);
        key_l_n = 1'b1;
        tick(20);

        // Right key bounce: two short lows rejected, final low accepted
        for (int i = 0; i < 2; i++) begin
            key_r_n = 1'b0; tick(3);
            key_r_n = 1'b1; tick(1);
        end
        key_r_n = 1'b0; expect_pulse(K_R);
        tick(20);
        key_r_n = 1'b1;
        tick(20);

        // Long hold with a short release glitch, then a fresh press
        key_l_n = 1'b0; expect_pulse(K_L);
        tick(25);
        key_l_n = 1'b1; tick(2);
        key_l_n = 1'b0; tick(23);
        key_l_n = 1'b1; tick(10);
        key_l_n = 1'b0; expect_pulse(K_L);
        tick(20);
        key_l_n = 1'b1;
        tick(20);

        // Simultaneous press -> tie
        key_l_n = 1'b0; key_r_n = 1'b0; expect_pulse(K_TIE);
        tick(20);
        key_l_n = 1'b1; key_r_n = 1'b1;
        tick(20);

        // Staggered by one cycle -> L then R
        key_l_n = 1'b0; expect_pulse(K_L);
        tick(1);
        key_r_n = 1'b0; expect_pulse(K_R);
        tick(20);
        key_l_n = 1'b1; key_r_n = 1'b1;
        tick(20);

        // Enable gating: acceptance while disabled is lost
        enable = 1'b0;
        key_l_n = 1'b0;
        tick(20);
        enable = 1'b1;
        tick(10);
        key_l_n = 1'b1;
        tick(20);
        key_l_n = 1'b0; expect_pulse(K_L);
        tick(20);
        key_l_n = 1'b1;
        tick(20);

        // Reset during PRESS_PEND, key still held when reset releases
        key_l_n = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(4);
        reset = 1'b0; expect_pulse(K_L);
        tick(20);
        key_l_n = 1'b1;
        tick(20);

        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
